instr_exec_unit: RTL

//  Downstream consumer of the Prg_C program-counter/fetch stage. Accepts an 8-bit instruction

---
 rtl/risc_pkg.sv | 35 +++
 rtl/risc_alu.sv | 41 ++++
 rtl/instr_exec_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// Shared types and instruction field positions for the small RISC datapath.
package risc_pkg;

  localparam int unsigned INSTR_W = 8;
  localparam int unsigned NREGS   = 4;

  // Instruction field slices: [7:5] opcode, [4:3] rd, [1:0] rs, [2:0] imm3
  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 5;
  localparam int unsigned RD_MSB  = 4;
  localparam int unsigned RD_LSB  = 3;
  localparam int unsigned RS_MSB  = 1;
  localparam int unsigned RS_LSB  = 0;
  localparam int unsigned IMM_MSB = 2;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LDI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_XOR  = 3'b101,
    OP_JZ   = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_e;

endpackage

// File: rtl/risc_alu.sv
// Combinational ALU: LDI passes b through, ADD/SUB report carry/borrow.
module risc_alu
  import risc_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;

  // Operation select; non-ALU opcodes yield zero with no carry
  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_LDI: result = b;
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND: result = a & b;
      OP_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/instr_exec_unit.sv
// Three-cycle FETCH/DECODE/EXEC instruction executor with 4x8 register file and Z/C flags.
module instr_exec_unit
  import risc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic               jump_valid,
  output logic [PC_W-1:0]    jump_target,
  output logic               halted,
  output logic [DATA_W-1:0]  acc_out,
  output logic               flag_z,
  output logic               flag_c
);

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  ir_q;
  logic [DATA_W-1:0]   rf_q [NREGS];
  logic [DATA_W-1:0]   op_a_q, op_b_q;
  logic                z_q, c_q;

  opcode_e             opc;
  logic [1:0]          rd, rs;
  logic [2:0]          imm;
  logic [DATA_W-1:0]   alu_b, alu_res;
  logic                alu_c, alu_z;
  logic                accept, alu_wb;

  assign opc    = opcode_e'(ir_q[OPC_MSB:OPC_LSB]);
  assign rd     = ir_q[RD_MSB:RD_LSB];
  assign rs     = ir_q[RS_MSB:RS_LSB];
  assign imm    = ir_q[IMM_MSB:IMM_LSB];
  assign accept = instr_valid && (state_q == S_FETCH);
  assign alu_wb = (opc == OP_LDI) || (opc == OP_ADD) || (opc == OP_SUB) ||
                  (opc == OP_AND) || (opc == OP_XOR);
  assign alu_b  = (opc == OP_LDI) ? DATA_W'(imm) : op_b_q;

  risc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (opc),
    .a      (op_a_q),
    .b      (alu_b),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Next-state logic; HALT is absorbing until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (accept) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (opc == OP_HALT) ? S_HALT : S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Datapath: latch instr, sample operands in DECODE, write back on leaving EXEC
  always_ff @(posedge clk) begin
    if (!rst) begin
      ir_q   <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      if (accept) ir_q <= instr;
      if (state_q == S_DECODE) begin
        op_a_q <= rf_q[rd];
        op_b_q <= rf_q[rs];
      end
      if (state_q == S_EXEC && alu_wb) begin
        rf_q[rd] <= alu_res;
        z_q      <= alu_z;
        c_q      <= alu_c;
      end
    end
  end

  // Outputs: status decoded from registered state; jump request is combinational in EXEC
  assign instr_ready = (state_q == S_FETCH);
  assign halted      = (state_q == S_HALT);
  assign acc_out     = rf_q[0];
  assign flag_z      = z_q;
  assign flag_c      = c_q;
  assign jump_valid  = rst && (state_q == S_EXEC) && (opc == OP_JZ) && z_q;
  assign jump_target = jump_valid ? PC_W'(imm) : '0;

endmodule
